// File: rtl/project_select_pkg.sv
// project_select_pkg
//   Shared definitions for the multi-project select controller:
//   register offsets inside the 256-byte Wishbone window, STATUS/CTRL
//   field positions, the sequencing state encoding and a byte-lane
//   merge helper used for Wishbone writes.
package project_select_pkg;

  localparam logic [7:0] CTRL_OFS   = 8'h00;
  localparam logic [7:0] STATUS_OFS = 8'h04;
  localparam logic [7:0] GUARD_OFS  = 8'h08;

  localparam int EN_BIT   = 31;
  localparam int BUSY_BIT = 8;
  localparam int ACT_BIT  = 9;
  localparam int ERR_BIT  = 10;
  localparam int OVR_BIT  = 11;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    GUARD = 2'd1,
    ON    = 2'd2
  } state_e;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/project_select_regs.sv
// project_select_regs
//   Wishbone slave front end for project_select_ctrl: address decode,
//   registered single-cycle ack, registered readback and CTRL/GUARD
//   storage. A CTRL write produces a one-cycle ctrl_wr pulse in the ack
//   cycle; ctrl_en/ctrl_idx always reflect the stored CTRL contents, so
//   during the pulse they carry the value just written.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stb, cyc, we, sel   Wishbone request qualifiers
//   adr, dat_i          byte address, write data
//   status_i            live STATUS word from the sequencer
//   ack, dat_o          registered acknowledge and read data
//   ctrl_wr             one-cycle pulse in the ack cycle of a CTRL write
//   ctrl_en, ctrl_idx   stored CTRL fields
//   guard               stored guard interval G
module project_select_regs
  import project_select_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  GUARD_RST = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        cyc,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] adr,
  input  logic [31:0] dat_i,
  input  logic [31:0] status_i,
  output logic        ack,
  output logic [31:0] dat_o,
  output logic        ctrl_wr,
  output logic        ctrl_en,
  output logic [7:0]  ctrl_idx,
  output logic [7:0]  guard
);

  logic        ack_q,     ack_d;
  logic [31:0] dat_o_q,   dat_o_d;
  logic        ctrl_wr_q, ctrl_wr_d;
  logic [31:0] ctrl_q,    ctrl_d;
  logic [7:0]  guard_q,   guard_d;
  logic        hit;
  logic        accept;
  logic [7:0]  ofs;

  always_comb begin
    hit       = stb & cyc & (adr[31:8] == BASE_ADDR[31:8]);
    // While ack is high the request is not taken again; the master sees
    // an ack every other cycle for back-to-back strobes.
    accept    = hit & ~ack_q;
    ofs       = adr[7:0];
    ack_d     = accept;
    dat_o_d   = '0;
    ctrl_wr_d = 1'b0;
    ctrl_d    = ctrl_q;
    guard_d   = guard_q;
    if (accept) begin
      if (we) begin
        case (ofs)
          CTRL_OFS: begin
            ctrl_d    = byte_merge(ctrl_q, dat_i, sel);
            ctrl_wr_d = 1'b1;
          end
          GUARD_OFS: begin
            if (sel[0]) guard_d = dat_i[7:0];
          end
          default: ;
        endcase
      end else begin
        case (ofs)
          CTRL_OFS:   dat_o_d = ctrl_q;
          STATUS_OFS: dat_o_d = status_i;
          GUARD_OFS:  dat_o_d = {24'd0, guard_q};
          default:    dat_o_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q     <= 1'b0;
      dat_o_q   <= '0;
      ctrl_wr_q <= 1'b0;
      ctrl_q    <= '0;
      guard_q   <= GUARD_RST;
    end else begin
      ack_q     <= ack_d;
      dat_o_q   <= dat_o_d;
      ctrl_wr_q <= ctrl_wr_d;
      ctrl_q    <= ctrl_d;
      guard_q   <= guard_d;
    end
  end

  assign ack      = ack_q;
  assign dat_o    = dat_o_q;
  assign ctrl_wr  = ctrl_wr_q;
  assign ctrl_en  = ctrl_q[EN_BIT];
  assign ctrl_idx = ctrl_q[7:0];
  assign guard    = guard_q;

endmodule

// File: rtl/project_select_ctrl.sv
// project_select_ctrl
//   Sequences the per-project `active` enables of the multi-project
//   harness so that at most one wrapped project drives the shared buses.
//   Switching is break-before-make: enables drop, a programmable guard
//   interval of G+1 cycles elapses, then the new project is enabled.
//   Optional build macro PROJECT_SELECT_LA_OVERRIDE_EN adds a logic
//   analyzer override of the selection (la_data_in/la_oen ports).
// Ports:
//   wb_clk_i, wb_rst_i    clock, synchronous active-high reset
//   wbs_*                 Wishbone slave (256-byte window at BASE_ADDR)
//   la_data_in, la_oen    override inputs (only with the macro defined)
//   active                one-hot or zero enable per project
//   proj_rst              per-project reset, ~active
//   busy                  high while the guard interval runs
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int          NUM_PROJECTS = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter logic [7:0]  GUARD_RST    = 8'd4,
  parameter int          IDX_W        = (NUM_PROJECTS > 1) ? $clog2(NUM_PROJECTS) : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_dat_i,
  input  logic [31:0]             wbs_adr_i,
`ifdef PROJECT_SELECT_LA_OVERRIDE_EN
  input  logic [31:0]             la_data_in,
  input  logic [31:0]             la_oen,
`endif
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] active,
  output logic [NUM_PROJECTS-1:0] proj_rst,
  output logic                    busy
);

  localparam logic [NUM_PROJECTS-1:0] ONE_HOT0 = NUM_PROJECTS'(1);
  localparam logic [8:0]              NP9      = 9'(NUM_PROJECTS);

  state_e                  state_q,    state_d;
  logic [7:0]              cnt_q,      cnt_d;
  logic [IDX_W-1:0]        cur_idx_q,  cur_idx_d;
  logic [IDX_W-1:0]        pend_idx_q, pend_idx_d;
  logic                    err_q,      err_d;
  logic [NUM_PROJECTS-1:0] active_q,   active_d;
  logic [NUM_PROJECTS-1:0] proj_rst_q, proj_rst_d;

  logic        ctrl_wr;
  logic        ctrl_en;
  logic [7:0]  ctrl_idx;
  logic [7:0]  guard;
  logic [31:0] status;
  logic        ovr_flag;

  // Selected request for this cycle (CTRL write or override event).
  logic        ap;
  logic        ap_en;
  logic [7:0]  ap_idx;

  project_select_regs #(
    .BASE_ADDR (BASE_ADDR),
    .GUARD_RST (GUARD_RST)
  ) u_regs (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .stb      (wbs_stb_i),
    .cyc      (wbs_cyc_i),
    .we       (wbs_we_i),
    .sel      (wbs_sel_i),
    .adr      (wbs_adr_i),
    .dat_i    (wbs_dat_i),
    .status_i (status),
    .ack      (wbs_ack_o),
    .dat_o    (wbs_dat_o),
    .ctrl_wr  (ctrl_wr),
    .ctrl_en  (ctrl_en),
    .ctrl_idx (ctrl_idx),
    .guard    (guard)
  );

`ifdef PROJECT_SELECT_LA_OVERRIDE_EN
  logic       ovr_q,     ovr_d;
  logic       tgt_en_q,  tgt_en_d;
  logic [7:0] tgt_idx_q, tgt_idx_d;
  logic       unused_la;

  assign unused_la = ^{la_data_in[29:0], la_oen[30:0]};

  // While the override holds, every change of the LA target behaves like
  // a CTRL write; on release the stored CTRL value is re-applied.
  always_comb begin
    ovr_d     = ~la_oen[31] & la_data_in[31];
    tgt_en_d  = la_data_in[30];
    tgt_idx_d = '0;
    tgt_idx_d[IDX_W-1:0] = la_data_in[IDX_W-1:0];
    ap        = 1'b0;
    ap_en     = 1'b0;
    ap_idx    = '0;
    if (ovr_d) begin
      if (!ovr_q || (tgt_en_d != tgt_en_q) || (tgt_idx_d != tgt_idx_q)) begin
        ap     = 1'b1;
        ap_en  = tgt_en_d;
        ap_idx = tgt_idx_d;
      end
    end else if (ovr_q) begin
      ap     = 1'b1;
      ap_en  = ctrl_en;
      ap_idx = ctrl_idx;
    end else begin
      ap     = ctrl_wr;
      ap_en  = ctrl_en;
      ap_idx = ctrl_idx;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovr_q     <= 1'b0;
      tgt_en_q  <= 1'b0;
      tgt_idx_q <= '0;
    end else begin
      ovr_q     <= ovr_d;
      tgt_en_q  <= tgt_en_d;
      tgt_idx_q <= tgt_idx_d;
    end
  end

  assign ovr_flag = ovr_q;
`else
  always_comb begin
    ap     = ctrl_wr;
    ap_en  = ctrl_en;
    ap_idx = ctrl_idx;
  end

  assign ovr_flag = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_idx_d  = cur_idx_q;
    pend_idx_d = pend_idx_q;
    err_d      = err_q;

    if (state_q == GUARD) begin
      if (cnt_q == 8'd0) begin
        state_d   = ON;
        cur_idx_d = pend_idx_q;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    // A request overrides the guard countdown decided above.
    if (ap) begin
      if ({1'b0, ap_idx} >= NP9) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
        if (!ap_en) begin
          state_d = OFF;
        end else if (!((state_q == ON) && (ap_idx[IDX_W-1:0] == cur_idx_q))) begin
          state_d    = GUARD;
          cnt_d      = guard;
          pend_idx_d = ap_idx[IDX_W-1:0];
        end
      end
    end

    // Enables are registered from the next state so they change together
    // with the state, never overlapping an old and a new project.
    active_d   = (state_d == ON) ? (ONE_HOT0 << cur_idx_d) : '0;
    proj_rst_d = ~active_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      cur_idx_q  <= '0;
      pend_idx_q <= '0;
      err_q      <= 1'b0;
      active_q   <= '0;
      proj_rst_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_idx_q  <= cur_idx_d;
      pend_idx_q <= pend_idx_d;
      err_q      <= err_d;
      active_q   <= active_d;
      proj_rst_q <= proj_rst_d;
    end
  end

  always_comb begin
    status                 = '0;
    status[IDX_W-1:0]      = cur_idx_q;
    status[BUSY_BIT]       = (state_q == GUARD);
    status[ACT_BIT]        = |active_q;
    status[ERR_BIT]        = err_q;
    status[OVR_BIT]        = ovr_flag;
  end

  assign active   = active_q;
  assign proj_rst = proj_rst_q;
  assign busy     = (state_q == GUARD);

endmodule

// File: doc/project_select_ctrl.md
Name: project_select_ctrl

Overview:
- Wishbone-configurable controller that sequences the per-project `active` enables of the multi-project harness.
- Guarantees at most one wrapped project drives the shared tristated Wishbone/LA/IO buses at any time.
- Switches break-before-make: all enables drop, a programmable guard interval elapses, then the new project is enabled.
- Sits beside the wrappers and drives one `active` bit per wrapper.

Parameters:
- NUM_PROJECTS, 8, number of wrapped projects (1..256).
- BASE_ADDR, 32'h3000_0000, Wishbone base address; block decodes a 256-byte window.
- GUARD_RST, 8'd4, reset value of the GUARD register.
- IDX_W, $clog2(NUM_PROJECTS) (min 1), width of a project index.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; writes honour them per byte.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- active  out  NUM_PROJECTS  one-hot or all-zero enable per project.
- proj_rst  out  NUM_PROJECTS  per-project reset, equal to ~active (registered).
- busy  out  1  high while in GUARD state.

Behaviour:
- Clocking/reset: single clock wb_clk_i; reset is synchronous and active-high on wb_rst_i.
- Reset values:
  - active=0, proj_rst=all ones, busy=0, wbs_ack_o=0, wbs_dat_o=0.
  - State OFF, cur_idx=0, pend_idx=0, GUARD=GUARD_RST, err=0.
- Address decode: hit = stb & cyc & (adr[31:8]==BASE_ADDR[31:8]).
- Wishbone timing:
  - wbs_ack_o is registered: asserted for exactly one cycle, the cycle after a hit.
  - No ack while ack is already high, so back-to-back strobes are acked every other cycle.
  - wbs_dat_o is valid only with ack; 0 otherwise.
- Registers (offset adr[7:0]):
  - 0x00 CTRL: [7:0] idx, [31] en. Read returns the last written value.
  - 0x04 STATUS (RO): [7:0] cur_idx, [8] busy, [9] |active, [10] err.
  - 0x08 GUARD: [7:0] guard cycles G.
  - Any other offset: acked, reads 0, writes ignored.
- CTRL write: takes effect in the ack cycle A.
  - idx >= NUM_PROJECTS: sets err and otherwise changes nothing.
  - Valid write: clears err.
- States:
  - OFF: active=0.
  - GUARD: active=0, 8-bit counter cnt.
  - ON: active=onehot(cur_idx).
- Transitions on a valid CTRL write:
  - en=0, from any state: OFF; active=0 from A+1.
  - en=1 from OFF, or from ON with idx!=cur_idx: GUARD, cnt=G, pend_idx=idx; active=0 from A+1.
  - en=1 from ON with idx==cur_idx: no change.
  - en=1 in GUARD: pend_idx=idx, cnt reloads to G (guard restarts).
- GUARD counting:
  - cnt==0: next state ON, cur_idx=pend_idx.
  - Otherwise cnt decrements.
  - Result: active asserts at cycle A+2+G. With G=0 the guard lasts exactly one cycle.
- Timing of other outputs:
  - proj_rst updates in the same cycle as active.
  - busy equals (state==GUARD).
- Invariant: popcount(active)<=1 in every cycle, including across reset.
- Reset mid-GUARD or mid-ON: next cycle OFF with all reset values; the pending selection is lost.
- GUARD write while busy: new G applies to the next reload only.

Optional Feature:
- Macro: PROJECT_SELECT_LA_OVERRIDE_EN.
- Defined:
  - Adds ports la_data_in[31:0] (in) and la_oen[31:0] (in).
  - Override is active when la_oen[31]==0 && la_data_in[31]==1.
  - While active, target = {en=la_data_in[30], idx=la_data_in[IDX_W-1:0]}, sampled every cycle.
  - A change in target is treated exactly like a CTRL write (same guard sequencing, err on invalid idx).
  - CTRL writes still update the register and are acked, but are not applied.
  - On override release, the CTRL register contents are applied as a fresh write.
  - STATUS[11] = override active.
- Undefined: ports absent, STATUS[11]=0.

Decomposition:
- Package project_select_pkg:
  - Register offsets: CTRL_OFS, STATUS_OFS, GUARD_OFS.
  - Field positions: EN_BIT=31, ERR_BIT=10, BUSY_BIT=8.
  - State enum {OFF, GUARD, ON}.
- Sub-module project_select_regs: Wishbone decode, ack/readback, register storage. It outputs a one-cycle ctrl_wr pulse with idx/en to the sequencing FSM in the top.

Test Plan:
- After reset, read STATUS -> 0x0000_0000; active=0, proj_rst=0xFF, GUARD reads 4.
- Write CTRL=0x8000_0003 (ack cycle A) -> active=0 through A+5, active=0x08 at A+6; busy high A+1..A+5; STATUS reads 0x203.
- From ON idx 3, write idx 5 -> active=0 at A+1, 0x20 at A+6. Every cycle of the run satisfies popcount(active)<=1.
- Write GUARD=0, then CTRL=0x8000_0001 -> active=0x02 at A+2. Next, write CTRL=0x8000_0009 (invalid idx 9) -> state unchanged, STATUS[10]=1.
- In GUARD at cnt=2, write idx 6 -> cnt reloads, active=0x40 exactly G+2 cycles after the second ack. Pulse wb_rst_i mid-GUARD -> active=0, STATUS=0 the next cycle.
- With PROJECT_SELECT_LA_OVERRIDE_EN: la_oen[31]=0, la_data_in=0xC000_0002 -> active=0x04 after the guard. A CTRL write of idx 1 is ignored. Release the override -> active moves to 0x02 after the guard.
